trace_round_controller: RTL and testbench

Sequences one spell-trace round on the 4x4 tracing grid. It generates a random 4-connected path, reveals it cell by cell on displayed_trace, and clears the player's trace through reset_trace. It then times the play window, judges the player's already_traced mask against the path, and keeps the score, including a snitch-cell bonus. It sits between the game FSM (start, learn_mode) and the grid renderer, which consumes displayed_trace, origin, next, reset_trace and snitch_location.

---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_path_gen.sv | 64 ++++++
 rtl/trace_round_controller.sv | 138 +++++++++++++
 tb/tb_trace_round_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and grid helpers for the spell-trace round controller.
package trace_pkg;
    localparam int GRID_DIM = 4;
    localparam int CELLS    = 16;
    localparam int MAX_PATH = 8;

    typedef logic [3:0] cell_t;

    typedef enum logic [2:0] {IDLE, BUILD, SHOW, SNITCH, CLEAR, PLAY, JUDGE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

    // Returns {valid, cell}; valid is 0 when the step would leave the grid.
    function automatic logic [4:0] neighbour(input cell_t c, input dir_t d);
        logic [4:0] r;
        r = {1'b0, c};
        case (d)
            DIR_UP:    if (c >= 4'(GRID_DIM))      r = {1'b1, c - 4'(GRID_DIM)};
            DIR_RIGHT: if (c[1:0] != 2'd3)         r = {1'b1, c + 4'd1};
            DIR_DOWN:  if (c < 4'(CELLS - GRID_DIM)) r = {1'b1, c + 4'(GRID_DIM)};
            default:   if (c[1:0] != 2'd0)         r = {1'b1, c - 4'd1};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/trace_path_gen.sv
// Free-running Galois LFSR plus the random 4-connected path builder.
module trace_path_gen
    import trace_pkg::*;
#(
    parameter int          PATH_LEN  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     build,
    output logic [3:0]               rnd,
    output logic [MAX_PATH-1:0][3:0] path,
    output logic [3:0]               len,
    output logic [CELLS-1:0]         mask,
    output logic                     done
);
    logic [15:0] lfsr;
    logic [2:0]  fails;
    dir_t        last_dir;
    dir_t        dir_try;
    cell_t       tail;
    logic [4:0]  cand;

    assign rnd     = lfsr[3:0];
    assign tail    = path[3'(len - 4'd1)];
    // A fresh random direction after each success, then walk clockwise on failures.
    assign dir_try = (fails == 3'd0) ? dir_t'(lfsr[1:0]) : dir_t'(last_dir + 2'd1);
    assign cand    = neighbour(tail, dir_try);
    assign done    = (len == 4'(PATH_LEN)) || (fails == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            path     <= '0;
            len      <= '0;
            mask     <= '0;
            fails    <= '0;
            last_dir <= DIR_UP;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (clear) begin
                path  <= '0;
                len   <= '0;
                mask  <= '0;
                fails <= '0;
            end else if (build && !done) begin
                if (len == 4'd0) begin
                    path[0] <= lfsr[3:0];
                    mask    <= 16'h1 << lfsr[3:0];
                    len     <= 4'd1;
                end else if (cand[4] && !mask[cand[3:0]]) begin
                    path[len[2:0]] <= cand[3:0];
                    mask           <= mask | (16'h1 << cand[3:0]);
                    len            <= len + 4'd1;
                    fails          <= '0;
                end else begin
                    fails    <= fails + 3'd1;
                    last_dir <= dir_try;
                end
            end
        end
    end
endmodule

// File: rtl/trace_round_controller.sv
// One spell-trace round: build path, reveal it, place snitch, time play, judge, score.
module trace_round_controller
    import trace_pkg::*;
#(
    parameter int          PATH_LEN     = 4,
    parameter int          SHOW_CYCLES  = 25000000,
    parameter int          PLAY_CYCLES  = 250000000,
    parameter int          SNITCH_BONUS = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        learn_mode,
    input  logic [15:0] already_traced,
    output logic [15:0] displayed_trace,
    output logic [5:0]  origin,
    output logic [5:0]  next,
    output logic        reset_trace,
    output logic [15:0] snitch_location,
    output logic        round_active,
    output logic        round_pass,
    output logic        round_fail,
    output logic [7:0]  score
);
    state_t                   state, state_nx;
    logic [31:0]              cnt;
    logic [3:0]               rnd;
    logic [MAX_PATH-1:0][3:0] path;
    logic [3:0]               len, shown;
    logic [CELLS-1:0]         path_mask;
    logic                     path_done, covered, show_tick, last_shown;
    cell_t                    snitch_c;
    logic [8:0]               score_sum;

    trace_path_gen #(.PATH_LEN(PATH_LEN), .LFSR_SEED(LFSR_SEED)) u_path (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE && start),
        .build (state == BUILD),
        .rnd   (rnd),
        .path  (path),
        .len   (len),
        .mask  (path_mask),
        .done  (path_done)
    );

    assign covered      = (already_traced & path_mask) == path_mask;
    assign show_tick    = cnt == 32'(SHOW_CYCLES - 1);
    assign last_shown   = shown >= len;
    assign round_active = state != IDLE;
    assign score_sum    = {1'b0, score} + 9'd1 +
                          (already_traced[snitch_c] ? 9'(SNITCH_BONUS) : 9'd0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = BUILD;
            BUILD:   if (path_done) state_nx = SHOW;
            SHOW:    if (show_tick && last_shown) state_nx = SNITCH;
            SNITCH:  if (!path_mask[snitch_c]) state_nx = CLEAR;
            CLEAR:   state_nx = PLAY;
            PLAY:    if (covered || cnt == 32'(PLAY_CYCLES - 1)) state_nx = JUDGE;
            JUDGE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            shown           <= '0;
            snitch_c        <= '0;
            displayed_trace <= '0;
            origin          <= '0;
            next            <= '0;
            reset_trace     <= 1'b0;
            snitch_location <= '0;
            round_pass      <= 1'b0;
            round_fail      <= 1'b0;
            score           <= '0;
        end else begin
            cnt         <= (state_nx != state) ? 32'd0 : cnt + 32'd1;
            reset_trace <= 1'b0;
            round_pass  <= 1'b0;
            round_fail  <= 1'b0;
            case (state)
                BUILD: begin
                    if (len == 4'd0) origin <= {2'b00, rnd};
                    if (state_nx == SHOW) begin
                        displayed_trace <= 16'h1 << path[0];
                        next            <= {2'b00, (len > 4'd1) ? path[1] : path[0]};
                        shown           <= 4'd1;
                    end
                end
                SHOW: if (show_tick) begin
                    cnt <= '0;
                    if (!last_shown) begin
                        displayed_trace <= displayed_trace | (16'h1 << path[shown[2:0]]);
                        next  <= {2'b00, (shown + 4'd1 < len) ? path[3'(shown + 4'd1)]
                                                             : path[3'(len - 4'd1)]};
                        shown <= shown + 4'd1;
                    end else begin
                        snitch_c <= rnd;
                    end
                end
                SNITCH: begin
                    if (path_mask[snitch_c]) begin
                        snitch_c <= snitch_c + 4'd1;
                    end else begin
                        reset_trace     <= 1'b1;
                        snitch_location <= 16'h1 << snitch_c;
                    end
                end
                CLEAR: if (!learn_mode) displayed_trace <= '0;
                // Verdict is registered on the way into JUDGE so the pulse shows during JUDGE.
                PLAY: if (state_nx == JUDGE) begin
                    if (covered) begin
                        round_pass <= 1'b1;
                        score      <= score_sum[8] ? 8'hFF : score_sum[7:0];
                    end else begin
                        round_fail <= 1'b1;
                    end
                end
                JUDGE: begin
                    displayed_trace <= '0;
                    snitch_location <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_round_controller.sv
// Scoreboard bench: stimulus pushes expected verdicts, a negedge monitor checks them.
module tb_trace_round_controller;
    logic        clk, reset, start, learn_mode;
    logic [15:0] already_traced, displayed_trace, snitch_location;
    logic [5:0]  origin, next_cell;
    logic        reset_trace, round_active, round_pass, round_fail;
    logic [7:0]  score;
    logic [55:0] all_outs;

    typedef struct {
        logic       pass;
        logic [7:0] score;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0, cyc = 0, rt_cyc = 0, score_m = 0;

    trace_round_controller #(
        .PATH_LEN(4), .SHOW_CYCLES(4), .PLAY_CYCLES(50), .SNITCH_BONUS(3), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .learn_mode      (learn_mode),
        .already_traced  (already_traced),
        .displayed_trace (displayed_trace),
        .origin          (origin),
        .next            (next_cell),
        .reset_trace     (reset_trace),
        .snitch_location (snitch_location),
        .round_active    (round_active),
        .round_pass      (round_pass),
        .round_fail      (round_fail),
        .score           (score)
    );

    assign all_outs = {displayed_trace, origin, next_cell, reset_trace, snitch_location,
                       round_active, round_pass, round_fail, score};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input logic ok, input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic adjacent(input int a, input int b);
        int dr, dc;
        dr = a / 4 - b / 4;
        dc = a % 4 - b % 4;
        return (dr == 0 && (dc == 1 || dc == -1)) || (dc == 0 && (dr == 1 || dr == -1));
    endfunction

    function automatic int onehot_idx(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitor: reveal order, reset_trace width, and verdict/score/latency scoreboard.
    initial begin
        logic [15:0] prev_disp, add;
        logic        prev_rt;
        int          last_cell, c;
        exp_t        e;
        prev_disp = '0; prev_rt = 1'b0; last_cell = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_disp = '0;
                prev_rt   = 1'b0;
            end else begin
                if (reset_trace) begin
                    chk(!prev_rt, "reset_trace_single", 64'(prev_rt), 64'd0);
                    rt_cyc = cyc;
                end
                prev_rt = reset_trace;
                add = displayed_trace & ~prev_disp;
                if (add != 0 && (displayed_trace & prev_disp) == prev_disp) begin
                    chk($countones(add) == 1, "reveal_onehot", 64'(add), 64'd1);
                    c = onehot_idx(add);
                    if (prev_disp == 0) begin
                        chk(c == int'(origin), "reveal_origin", 64'(c), 64'(origin));
                    end else begin
                        chk(adjacent(last_cell, c), "reveal_adjacent", 64'(c), 64'(last_cell));
                    end
                    last_cell = c;
                end
                prev_disp = displayed_trace;
                if (round_pass || round_fail) begin
                    chk(exp_q.size() != 0, "unexpected_pulse", {round_pass, round_fail}, 64'd0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk({round_pass, round_fail} == {e.pass, !e.pass}, "verdict",
                            {round_pass, round_fail}, {e.pass, !e.pass});
                        chk(score == e.score, "score", 64'(score), 64'(e.score));
                        chk(cyc - rt_cyc == e.lat, "verdict_latency", 64'(cyc - rt_cyc), 64'(e.lat));
                    end
                end
            end
        end
    end

    // mode 0: exact path, 1: nothing, 2: path+snitch, 3: all cells
    task automatic do_round(input int mode, input logic learn);
        logic [15:0] pm, sn, drv;
        logic        pass;
        int          n, s;
        exp_t        e;
        @(negedge clk);
        start = 1'b1; learn_mode = learn;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!reset_trace && n < 400) begin @(negedge clk); n++; end
        chk(reset_trace, "reset_trace_timeout", 64'(n), 64'd400);
        if (!reset_trace) return;
        pm = displayed_trace;
        sn = snitch_location;
        chk($countones(pm) >= 1 && $countones(pm) <= 4, "path_popcount", 64'(pm), 64'd4);
        chk(pm[origin[3:0]] && origin[5:4] == 2'b00, "origin_in_path", 64'(origin), 64'(pm));
        chk($countones(sn) == 1 && (sn & pm) == 0, "snitch_off_path", 64'(sn), 64'(pm));
        case (mode)
            0:       drv = pm;
            1:       drv = 16'h0000;
            2:       drv = pm | sn;
            default: drv = 16'hFFFF;
        endcase
        pass = (drv & pm) == pm;
        if (pass) begin
            s = score_m + 1 + (((drv & sn) != 0) ? 3 : 0);
            score_m = (s > 255) ? 255 : s;
        end
        e.pass = pass; e.score = 8'(score_m); e.lat = pass ? 2 : 51;
        exp_q.push_back(e);
        @(negedge clk);
        chk(displayed_trace == (learn ? pm : 16'h0), "play_display", 64'(displayed_trace),
            64'(learn ? pm : 16'h0));
        already_traced = drv;
        n = 0;
        while (!(round_pass || round_fail) && n < 100) begin @(negedge clk); n++; end
        chk(round_pass || round_fail, "verdict_timeout", 64'(n), 64'd100);
        if (!(round_pass || round_fail)) exp_q.delete();
        already_traced = '0;
    endtask

    // Start a round W cycles after reset release, reset it at the 3rd reveal.
    task automatic mid_reset(output logic [15:0] d, output logic [5:0] o);
        int n;
        repeat (5) @(negedge clk);
        start = 1'b1; learn_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ($countones(displayed_trace) != 3 && n < 200) begin @(negedge clk); n++; end
        chk($countones(displayed_trace) == 3, "third_reveal_timeout", 64'(n), 64'd200);
        d = displayed_trace;
        o = origin;
        reset = 1'b1;
        @(negedge clk);
        chk(all_outs == 0 && score == 0, "mid_reset_outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;
        score_m = 0;
    endtask

    initial begin
        logic [15:0] d0, d1, d2;
        logic [5:0]  o0, o1, o2;
        reset = 1'b1; start = 1'b0; learn_mode = 1'b0; already_traced = '0;
        repeat (3) @(negedge clk);
        chk(all_outs == 0, "reset_outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;

        do_round(0, 1'b0);
        do_round(1, 1'b0);

        mid_reset(d0, o0);
        mid_reset(d1, o1);
        mid_reset(d2, o2);
        chk({d1, o1} == {d2, o2}, "replay_path", 64'({d2, o2}), 64'({d1, o1}));

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 9)) @(negedge clk);
            do_round(i % 3, 1'($urandom_range(0, 1)));
        end

        do_round(2, 1'b1);

        for (int i = 0; i < 260; i++) do_round(3, 1'b0);
        chk(score == 8'd255, "score_saturated", 64'(score), 64'd255);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
